sdram_cmd_sequencer: RTL and testbench

Downstream stage of the SDRAM control interface. It consumes the decoded command strobes (READA/WRITEA/REFRESH/PRECHARGE/LOAD_MODE), the registered address SADDR and the hidden REF_REQ/INIT_REQ requests. It drives the SDRAM command pins with correct tRCD/CL/tRP/tRFC/tMRD spacing. It returns CM_ACK, REF_ACK and INIT_ACK to the control interface, and emits write-enable and read-valid windows for the data path.

---
 rtl/sdram_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_sdram_cmd_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer: turns decoded host/init commands into SDRAM command
// pins with tRCD/CL/tRP/tRFC/tMRD spacing, acks and data-path windows.
//
// Ports:
//   CLK, RESET_N               clock, async active-low reset
//   NOP, READA, WRITEA         host command levels (held until ack)
//   REFRESH, PRECHARGE,
//   LOAD_MODE                  single-cycle init strobes
//   SADDR[ASIZE-1:0]           {bank, row, col}
//   REF_REQ, INIT_REQ          refresh request, power-up hold-off
//   CM_ACK, REF_ACK, INIT_ACK  one-cycle acks, coincident with command
//   SA, BA, CS_N, RAS_N,
//   CAS_N, WE_N, CKE, DQM      SDRAM pins (registered)
//   WR_EN, RD_VALID            data-path drive/capture windows
module sdram_cmd_sequencer #(
   parameter int ASIZE   = 22,
   parameter int ROWSIZE = 12,
   parameter int COLSIZE = 8,
   parameter int BL      = 4,
   parameter int CL      = 3,
   parameter int TRCD    = 3,
   parameter int TRP     = 3,
   parameter int TRFC    = 7,
   parameter int TMRD    = 2,
   parameter int TWR     = 2,
   parameter logic [ROWSIZE-1:0] MODE_REG = 12'h032
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               NOP,
   input  logic               READA,
   input  logic               WRITEA,
   input  logic               REFRESH,
   input  logic               PRECHARGE,
   input  logic               LOAD_MODE,
   input  logic [ASIZE-1:0]   SADDR,
   input  logic               REF_REQ,
   input  logic               INIT_REQ,
   output logic               CM_ACK,
   output logic               REF_ACK,
   output logic               INIT_ACK,
   output logic [ROWSIZE-1:0] SA,
   output logic [1:0]         BA,
   output logic               CS_N,
   output logic               RAS_N,
   output logic               CAS_N,
   output logic               WE_N,
   output logic               CKE,
   output logic [1:0]         DQM,
   output logic               WR_EN,
   output logic               RD_VALID
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACT_WAIT,
      S_RW,
      S_BUSY
   } state_t;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   localparam int N_RD = CL + BL + TRP;
   localparam int N_WR = BL + TWR + TRP;

   localparam logic [ROWSIZE-1:0] A10 = ROWSIZE'(1 << 10);

   state_t             state_q;
   logic [7:0]         cnt_q;
   logic [3:0]         cmd_q;
   logic [ROWSIZE-1:0] sa_q;
   logic [ROWSIZE-1:0] rw_sa;
   logic [1:0]         ba_q;
   logic [1:0]         bank_q;
   logic [COLSIZE-1:0] col_q;
   logic               is_rd_q;
   logic               pend_pre_q;
   logic               pend_ref_q;
   logic               pend_lm_q;
   logic               pre_any;
   logic               ref_any;
   logic               lm_any;
   logic               cm_ack_q;
   logic               ref_ack_q;
   logic               init_ack_q;
   logic [1:0]         dqm_q;
   logic               wr_en_q;
   logic               rd_valid_q;
   logic [7:0]         rd_cnt_q;
   logic [7:0]         rd_cnt_d;
   logic [7:0]         wr_cnt_q;
   logic [7:0]         wr_cnt_d;
   logic               unused_nop;

   assign unused_nop = NOP;

   // A strobe arriving on the very edge it can issue counts as pending.
   assign lm_any  = pend_lm_q  | LOAD_MODE;
   assign pre_any = pend_pre_q | PRECHARGE;
   assign ref_any = pend_ref_q | REFRESH;

   assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
   assign SA       = sa_q;
   assign BA       = ba_q;
   assign CKE      = 1'b1;
   assign DQM      = dqm_q;
   assign CM_ACK   = cm_ack_q;
   assign REF_ACK  = ref_ack_q;
   assign INIT_ACK = init_ack_q;
   assign WR_EN    = wr_en_q;
   assign RD_VALID = rd_valid_q;

   // Counter load for a busy span of n cycles until the next command.
   function automatic logic [7:0] bcnt(input int n);
      return 8'(n - 2);
   endfunction

   function automatic state_t bstate(input int n);
      return (n > 1) ? S_BUSY : S_IDLE;
   endfunction

   always_comb begin
      rw_sa = '0;
      rw_sa[10] = 1'b1;
      rw_sa[COLSIZE-1:0] = col_q;
   end

   // Data windows: read counter covers CL latency then BL valid beats.
   always_comb begin
      rd_cnt_d = (rd_cnt_q != '0) ? rd_cnt_q - 8'd1 : '0;
      wr_cnt_d = (wr_cnt_q != '0) ? wr_cnt_q - 8'd1 : '0;
      if (state_q == S_RW) begin
         if (is_rd_q) rd_cnt_d = 8'(CL + BL);
         else         wr_cnt_d = 8'(BL);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cmd_q      <= C_NOP;
         sa_q       <= '0;
         ba_q       <= '0;
         bank_q     <= '0;
         col_q      <= '0;
         is_rd_q    <= 1'b0;
         pend_pre_q <= 1'b0;
         pend_ref_q <= 1'b0;
         pend_lm_q  <= 1'b0;
         cm_ack_q   <= 1'b0;
         ref_ack_q  <= 1'b0;
         init_ack_q <= 1'b0;
         dqm_q      <= 2'b11;
         wr_en_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
      end else begin
         cmd_q      <= C_NOP;
         sa_q       <= '0;
         ba_q       <= '0;
         cm_ack_q   <= 1'b0;
         ref_ack_q  <= 1'b0;
         init_ack_q <= 1'b0;
         dqm_q      <= {2{INIT_REQ}};
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_en_q    <= (wr_cnt_d != '0);
         rd_valid_q <= (rd_cnt_d != '0) && (rd_cnt_d <= 8'(BL));
         pend_lm_q  <= lm_any;
         pend_pre_q <= pre_any;
         pend_ref_q <= ref_any;
         unique case (state_q)
            S_IDLE: begin
               if (INIT_REQ) begin
                  state_q <= S_IDLE;
               end else if (lm_any) begin
                  cmd_q      <= C_LMR;
                  sa_q       <= MODE_REG;
                  init_ack_q <= 1'b1;
                  pend_lm_q  <= 1'b0;
                  state_q    <= bstate(TMRD);
                  cnt_q      <= bcnt(TMRD);
               end else if (pre_any) begin
                  cmd_q      <= C_PRE;
                  sa_q       <= A10;
                  pend_pre_q <= 1'b0;
                  state_q    <= bstate(TRP);
                  cnt_q      <= bcnt(TRP);
               end else if (ref_any) begin
                  cmd_q      <= C_REF;
                  pend_ref_q <= 1'b0;
                  state_q    <= bstate(TRFC);
                  cnt_q      <= bcnt(TRFC);
               end else if (REF_REQ) begin
                  cmd_q     <= C_REF;
                  ref_ack_q <= 1'b1;
                  state_q   <= bstate(TRFC);
                  cnt_q     <= bcnt(TRFC);
               end else if (READA || WRITEA) begin
                  cmd_q   <= C_ACT;
                  sa_q    <= SADDR[COLSIZE +: ROWSIZE];
                  ba_q    <= SADDR[COLSIZE+ROWSIZE +: 2];
                  bank_q  <= SADDR[COLSIZE+ROWSIZE +: 2];
                  col_q   <= SADDR[COLSIZE-1:0];
                  is_rd_q <= READA;
                  state_q <= (TRCD > 1) ? S_ACT_WAIT : S_RW;
                  cnt_q   <= 8'(TRCD - 2);
               end
            end
            S_ACT_WAIT: begin
               if (cnt_q == '0) state_q <= S_RW;
               else             cnt_q   <= cnt_q - 8'd1;
            end
            S_RW: begin
               cmd_q    <= is_rd_q ? C_RD : C_WR;
               sa_q     <= rw_sa;
               ba_q     <= bank_q;
               cm_ack_q <= 1'b1;
               state_q  <= is_rd_q ? bstate(N_RD) : bstate(N_WR);
               cnt_q    <= is_rd_q ? bcnt(N_RD) : bcnt(N_WR);
            end
            S_BUSY: begin
               if (cnt_q == '0) state_q <= S_IDLE;
               else             cnt_q   <= cnt_q - 8'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb_sdram_cmd_sequencer: scoreboard bench; a timeline model schedules
// expected pin events per cycle, a negedge monitor compares them.
module tb_sdram_cmd_sequencer;

   localparam int TRCD = 3;
   localparam int CL   = 3;
   localparam int BL   = 4;
   localparam int TRP  = 3;
   localparam int TRFC = 7;
   localparam int TMRD = 2;
   localparam int TWR  = 2;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        NOP = 1'b0;
   logic        READA = 1'b0;
   logic        WRITEA = 1'b0;
   logic        REFRESH = 1'b0;
   logic        PRECHARGE = 1'b0;
   logic        LOAD_MODE = 1'b0;
   logic [21:0] SADDR = '0;
   logic        REF_REQ = 1'b0;
   logic        INIT_REQ = 1'b1;
   logic        CM_ACK, REF_ACK, INIT_ACK;
   logic [11:0] SA;
   logic [1:0]  BA;
   logic        CS_N, RAS_N, CAS_N, WE_N, CKE;
   logic [1:0]  DQM;
   logic        WR_EN, RD_VALID;

   sdram_cmd_sequencer dut (
      .CLK(CLK), .RESET_N(RESET_N), .NOP(NOP), .READA(READA),
      .WRITEA(WRITEA), .REFRESH(REFRESH), .PRECHARGE(PRECHARGE),
      .LOAD_MODE(LOAD_MODE), .SADDR(SADDR), .REF_REQ(REF_REQ),
      .INIT_REQ(INIT_REQ), .CM_ACK(CM_ACK), .REF_ACK(REF_ACK),
      .INIT_ACK(INIT_ACK), .SA(SA), .BA(BA), .CS_N(CS_N),
      .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .CKE(CKE),
      .DQM(DQM), .WR_EN(WR_EN), .RD_VALID(RD_VALID)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  cmd;
      logic [11:0] sa;
      logic [1:0]  ba;
      bit          chk_sa;
      bit          a10_only;
      bit          cm;
      bit          ra;
      bit          ia;
   } exp_t;

   exp_t exp_cmd[int];
   bit   exp_wr[int];
   bit   exp_rd[int];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   free_at = 0;
   int   last_issue = 0;
   logic rst_s = 1'b0;
   logic init_s = 1'b1;

   always @(posedge CLK) begin
      cyc    <= cyc + 1;
      rst_s  <= RESET_N;
      init_s <= INIT_REQ;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic int mx(int a, int b);
      return (a > b) ? a : b;
   endfunction

   task automatic put(int t, logic [3:0] c, logic [11:0] sa,
                      logic [1:0] ba, bit cs, bit a10,
                      bit cm, bit ra, bit ia);
      exp_t e;
      e.cmd = c; e.sa = sa; e.ba = ba;
      e.chk_sa = cs; e.a10_only = a10;
      e.cm = cm; e.ra = ra; e.ia = ia;
      exp_cmd[t] = e;
      last_issue = mx(last_issue, t);
   endtask

   // Read/write transaction whose ACTIVE lands on cycle t.
   task automatic m_rw(bit rd, int t, logic [21:0] a);
      int r;
      logic [11:0] rw_sa;
      r = t + TRCD;
      rw_sa = 12'h400 | {4'h0, a[7:0]};
      put(t, C_ACT, a[19:8], a[21:20], 1, 0, 0, 0, 0);
      put(r, rd ? C_RD : C_WR, rw_sa, a[21:20], 1, 0, 1, 0, 0);
      for (int i = 0; i < BL; i++) begin
         if (rd) exp_rd[r + CL + i] = 1'b1;
         else    exp_wr[r + i] = 1'b1;
      end
      free_at = r + (rd ? (CL + BL + TRP) : (BL + TWR + TRP));
   endtask

   // k: 0 precharge, 1 init refresh, 2 load mode, 3 requested refresh
   task automatic m_other(int k, int t);
      case (k)
         0: begin
            put(t, C_PRE, 12'h400, 2'd0, 1, 1, 0, 0, 0);
            free_at = t + TRP;
         end
         1: begin
            put(t, C_REF, 12'h0, 2'd0, 0, 0, 0, 0, 0);
            free_at = t + TRFC;
         end
         2: begin
            put(t, C_LMR, 12'h032, 2'd0, 1, 0, 0, 0, 1);
            free_at = t + TMRD;
         end
         default: begin
            put(t, C_REF, 12'h0, 2'd0, 0, 0, 0, 1, 0);
            free_at = t + TRFC;
         end
      endcase
   endtask

   always @(negedge CLK) begin : mon
      exp_t e;
      if (!RESET_N) begin
         chk("rst_cmd", {CS_N, RAS_N, CAS_N, WE_N}, C_NOP);
         chk("rst_sa", SA, 0);
         chk("rst_ba", BA, 0);
         chk("rst_flags", {CM_ACK, REF_ACK, INIT_ACK, WR_EN, RD_VALID}, 0);
         chk("rst_dqm", DQM, 3);
         chk("rst_cke", CKE, 1);
      end else begin
         e.cmd = C_NOP; e.sa = '0; e.ba = '0;
         e.chk_sa = 0; e.a10_only = 0;
         e.cm = 0; e.ra = 0; e.ia = 0;
         if (exp_cmd.exists(cyc)) begin
            e = exp_cmd[cyc];
            exp_cmd.delete(cyc);
         end
         chk("cmd", {CS_N, RAS_N, CAS_N, WE_N}, e.cmd);
         chk("acks", {CM_ACK, REF_ACK, INIT_ACK}, {e.cm, e.ra, e.ia});
         if (e.chk_sa) begin
            if (e.a10_only) begin
               chk("sa10", SA[10], 1);
            end else begin
               chk("sa", SA, e.sa);
               chk("ba", BA, e.ba);
            end
         end
         chk("wr_en", WR_EN, exp_wr.exists(cyc));
         chk("rd_valid", RD_VALID, exp_rd.exists(cyc));
         chk("dqm", DQM, rst_s ? (init_s ? 3 : 0) : 3);
         chk("cke", CKE, 1);
      end
   end

   task automatic wait_to(int c);
      while (cyc < c) @(negedge CLK);
   endtask

   task automatic host_rw(bit rd, logic [21:0] a);
      int t;
      SADDR = a;
      if (rd) READA = 1'b1;
      else    WRITEA = 1'b1;
      t = mx(cyc + 1, free_at);
      m_rw(rd, t, a);
      wait_to(t + TRCD + 3);
      READA = 1'b0;
      WRITEA = 1'b0;
   endtask

   task automatic strobe(int k);
      m_other(k, mx(cyc + 1, free_at));
      case (k)
         0: PRECHARGE = 1'b1;
         1: REFRESH = 1'b1;
         default: LOAD_MODE = 1'b1;
      endcase
      @(negedge CLK);
      PRECHARGE = 1'b0;
      REFRESH = 1'b0;
      LOAD_MODE = 1'b0;
   endtask

   task automatic refreq();
      int t;
      REF_REQ = 1'b1;
      t = mx(cyc + 1, free_at);
      m_other(3, t);
      wait_to(t);
      REF_REQ = 1'b0;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int t, r;
      logic [21:0] a;
      @(negedge CLK);
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      repeat (50) @(negedge CLK);
      INIT_REQ = 1'b0;
      repeat (5) @(negedge CLK);

      // power-up init sequence
      strobe(0);
      for (int i = 0; i < 8; i++) begin
         repeat (19) @(negedge CLK);
         strobe(1);
      end
      repeat (19) @(negedge CLK);
      strobe(2);
      wait_to(free_at + 2);

      // directed read
      host_rw(1, 22'h2A5C3F);
      wait_to(free_at);

      // write held alongside refresh request
      a = 22'($urandom);
      SADDR = a;
      WRITEA = 1'b1;
      REF_REQ = 1'b1;
      t = mx(cyc + 1, free_at);
      m_other(3, t);
      m_rw(0, free_at, a);
      wait_to(t);
      REF_REQ = 1'b0;
      wait_to(t + TRFC + TRCD + 3);
      WRITEA = 1'b0;
      wait_to(free_at);

      // refresh strobe two cycles after READ
      a = 22'($urandom);
      SADDR = a;
      READA = 1'b1;
      t = mx(cyc + 1, free_at);
      m_rw(1, t, a);
      r = t + TRCD;
      wait_to(r + 1);
      strobe(1);
      wait_to(r + 3);
      READA = 1'b0;
      wait_to(free_at + 1);

      // read held off by INIT_REQ
      a = 22'($urandom);
      SADDR = a;
      INIT_REQ = 1'b1;
      READA = 1'b1;
      repeat (10) @(negedge CLK);
      INIT_REQ = 1'b0;
      t = cyc + 1;
      m_rw(1, t, a);
      wait_to(t + TRCD + 3);
      READA = 1'b0;
      wait_to(free_at);

      // reset in the middle of a write burst
      a = 22'($urandom);
      SADDR = a;
      WRITEA = 1'b1;
      t = mx(cyc + 1, free_at);
      m_rw(0, t, a);
      wait_to(t + TRCD + 1);
      @(posedge CLK);
      #2;
      RESET_N = 1'b0;
      WRITEA = 1'b0;
      exp_cmd.delete();
      exp_wr.delete();
      exp_rd.delete();
      free_at = 0;
      #1;
      chk("async_rst_cmd", {CS_N, RAS_N, CAS_N, WE_N}, C_NOP);
      chk("async_rst_cm_ack", CM_ACK, 0);
      chk("async_rst_wr_en", WR_EN, 0);
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);
      host_rw(1, 22'($urandom));
      wait_to(free_at);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         int k, tgt;
         k = int'($urandom_range(0, 5));
         tgt = mx(free_at - int'($urandom_range(0, 6)), last_issue);
         wait_to(tgt);
         case (k)
            0: host_rw(1, 22'($urandom));
            1: host_rw(0, 22'($urandom));
            2: refreq();
            default: strobe(k - 3);
         endcase
      end

      wait_to(free_at + 20);
      chk("leftover_events", exp_cmd.num(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
